// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module  : cpu_types_pkg
// Brief   : Shared CPU/memory-side types: RAM status, arbiter states, word width.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/arb_streak_ctr.sv
// ============================================================================
// Module  : arb_streak_ctr
// Brief   : Saturating count of consecutive dcache grants taken while the icache waits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_streak_ctr #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_sat
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != W'(MAX))) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_sat = (r_cnt == W'(MAX));

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Brief   : dcache/icache arbiter onto one RAM port; dcache priority, burst hold,
//           bounded icache starvation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int BURST_LEN    = 2,
    parameter int D_STREAK_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    localparam int CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int STREAK_W = $clog2(D_STREAK_MAX + 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [CNT_W-1:0]   w_word_cnt_nxt;
    logic               r_ram_err;
    logic               w_streak_clr;
    logic               w_streak_inc;
    logic               w_streak_sat;
    logic               w_dreq;
    logic               w_access;

    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == ACCESS);
    assign ram_err  = r_ram_err;

    arb_streak_ctr #(
        .MAX (D_STREAK_MAX),
        .W   (STREAK_W)
    ) u_streak (
        .clk   (CLK),
        .rst   (RST),
        .i_clr (w_streak_clr),
        .i_inc (w_streak_inc),
        .o_sat (w_streak_sat)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_word_cnt <= '0;
            r_ram_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            if ((r_state != IDLE) && (ramstate == ERROR)) begin
                r_ram_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_streak_clr   = 1'b0;
        w_streak_inc   = 1'b0;
        ramREN         = 1'b0;
        ramWEN         = 1'b0;
        ramaddr        = '0;
        ramstore       = '0;
        dwait          = 1'b1;
        iwait          = 1'b1;
        dload          = ramload;
        iload          = ramload;

        case (r_state)
            IDLE: begin
                // A saturated streak with the icache waiting hands the next slot to the icache.
                if (w_dreq && !(iREN && w_streak_sat)) begin
                    w_state_nxt  = DGRANT;
                    w_streak_inc = iREN;
                    w_streak_clr = ~iREN;
                end else if (iREN) begin
                    w_state_nxt  = IGRANT;
                    w_streak_clr = 1'b1;
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~w_access;
                if (!w_dreq) begin
                    w_state_nxt    = IDLE;
                    w_word_cnt_nxt = '0;
                end else begin
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;
                    if (w_access) begin
                        if (r_word_cnt == CNT_W'(BURST_LEN - 1)) begin
                            w_state_nxt    = IDLE;
                            w_word_cnt_nxt = '0;
                        end else begin
                            w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~w_access;
                if (w_access || !iREN) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed plus randomized bench for mem_arbiter against a grant-owner model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int BL   = 2;
    localparam int SMAX = 4;

    logic        CLK = 1'b0;
    logic        RST, dREN, dWEN, iREN;
    logic [31:0] daddr, dstore, iaddr, ramload;
    logic [1:0]  ramstate;
    logic [31:0] dload, iload, ramaddr, ramstore;
    logic        dwait, iwait, ramREN, ramWEN, ram_err;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .BURST_LEN    (BL),
        .D_STREAK_MAX (SMAX)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ram_err  (ram_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the RAM port (0 none, 1 dcache, 2 icache), words finished
    // in the current dcache block, dcache grants in a row while icache waited.
    int m_owner  = 0;
    int m_words  = 0;
    int m_streak = 0;
    bit m_err    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clock(input bit rst, input bit dr, input bit dw, input bit ir,
                               input logic [1:0] rs);
        bit dreq;
        bit acc;
        dreq = dr | dw;
        acc  = (rs == 2'd2);
        if (rst) begin
            m_owner = 0; m_words = 0; m_streak = 0; m_err = 1'b0;
        end else begin
            if (m_owner != 0 && rs == 2'd3) m_err = 1'b1;
            if (m_owner == 0) begin
                if (dreq && !(ir && m_streak == SMAX)) begin
                    m_owner  = 1;
                    m_streak = ir ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
                end else if (ir) begin
                    m_owner  = 2;
                    m_streak = 0;
                end
            end else if (m_owner == 1) begin
                if (!dreq) begin
                    m_owner = 0; m_words = 0;
                end else if (acc) begin
                    m_words++;
                    if (m_words == BL) begin
                        m_owner = 0; m_words = 0;
                    end
                end
            end else begin
                if (acc || !ir) m_owner = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance one clock.
    task automatic step(input bit rst, input bit dr, input bit dw, input bit ir,
                        input logic [31:0] da, input logic [31:0] ds, input logic [31:0] ia,
                        input logic [1:0] rs);
        logic        e_ren, e_wen, e_dw, e_iw;
        logic [31:0] e_addr, e_store;
        bit          acc;
        RST = rst; dREN = dr; dWEN = dw; iREN = ir;
        daddr = da; dstore = ds; iaddr = ia; ramstate = rs;
        ramload = $urandom;
        #3;
        acc = (rs == 2'd2);
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0; e_dw = 1'b1; e_iw = 1'b1;
        if (m_owner == 1) begin
            e_addr  = da;
            e_store = ds;
            e_dw    = ~acc;
            if (dr | dw) begin
                e_wen = dw;
                e_ren = dr & ~dw;
            end
        end else if (m_owner == 2) begin
            e_ren  = ir;
            e_addr = ia;
            e_iw   = ~acc;
        end
        check("ramREN",   {31'd0, ramREN},  {31'd0, e_ren});
        check("ramWEN",   {31'd0, ramWEN},  {31'd0, e_wen});
        check("ramaddr",  ramaddr,          e_addr);
        check("ramstore", ramstore,         e_store);
        check("dwait",    {31'd0, dwait},   {31'd0, e_dw});
        check("iwait",    {31'd0, iwait},   {31'd0, e_iw});
        check("ram_err",  {31'd0, ram_err}, {31'd0, m_err});
        check("dload",    dload,            ramload);
        check("iload",    iload,            ramload);
        @(posedge CLK);
        model_clock(rst, dr, dw, ir, rs);
        #1;
    endtask

    logic [1:0] rs_r;
    int         r;

    initial begin
        RST = 1'b1; dREN = 0; dWEN = 0; iREN = 0;
        daddr = 0; dstore = 0; iaddr = 0; ramload = 0; ramstate = 2'd0;
        @(posedge CLK);
        model_clock(1'b1, 0, 0, 0, 2'd0);
        #1;

        // Reset state, then best-case dcache read burst
        step(1, 0, 0, 0, 0, 0, 0, 2'd0);
        step(0, 1, 0, 0, 32'h100, 0, 0, 2'd2);
        check("plan_d_ren0",  {31'd0, ramREN}, 32'd1);
        check("plan_d_addr0", ramaddr, 32'h100);
        check("plan_d_wait0", {31'd0, dwait}, 32'd0);
        step(0, 1, 0, 0, 32'h100, 0, 0, 2'd2);
        step(0, 1, 0, 0, 32'h104, 0, 0, 2'd2);
        step(0, 0, 0, 0, 32'h104, 0, 0, 2'd2);

        // Simultaneous write and icache read
        step(1, 0, 0, 0, 0, 0, 0, 2'd0);
        step(0, 1, 1, 1, 32'h180, 32'hDEAD, 32'h40, 2'd2);
        check("plan_w_wen", {31'd0, ramWEN}, 32'd1);
        step(0, 0, 1, 1, 32'h180, 32'hDEAD, 32'h40, 2'd2);
        step(0, 0, 1, 1, 32'h184, 32'hBEEF, 32'h40, 2'd2);
        step(0, 0, 0, 1, 32'h184, 32'hBEEF, 32'h40, 2'd2);
        check("plan_w_iaddr", ramaddr, 32'h40);
        step(0, 0, 0, 1, 0, 0, 32'h40, 2'd2);

        // Starvation guard: four dcache bursts, then the icache gets the port
        step(1, 0, 0, 0, 0, 0, 0, 2'd0);
        for (int b = 0; b < SMAX * 3; b++)
            step(0, 1, 0, 1, 32'h400 + 32'(b), 0, 32'h200, 2'd2);
        step(0, 1, 0, 1, 32'h500, 0, 32'h200, 2'd2);
        check("plan_s_iaddr", ramaddr, 32'h200);
        check("plan_s_dwait", {31'd0, dwait}, 32'd1);
        for (int b = 0; b < 4; b++)
            step(0, 1, 0, 1, 32'h600, 0, 32'h200, 2'd2);

        // BUSY stretches word 0
        step(1, 0, 0, 0, 0, 0, 0, 2'd0);
        step(0, 1, 0, 0, 32'h300, 0, 0, 2'd2);
        repeat (3) step(0, 1, 0, 0, 32'h300, 0, 0, 2'd1);
        step(0, 1, 0, 0, 32'h300, 0, 0, 2'd2);
        step(0, 1, 0, 0, 32'h304, 0, 0, 2'd2);
        step(0, 0, 0, 0, 0, 0, 0, 2'd0);

        // ERROR during an icache grant
        step(1, 0, 0, 0, 0, 0, 0, 2'd0);
        step(0, 0, 0, 1, 0, 0, 32'h80, 2'd0);
        step(0, 0, 0, 1, 0, 0, 32'h80, 2'd3);
        step(0, 0, 0, 1, 0, 0, 32'h80, 2'd2);
        check("plan_e_sticky", {31'd0, ram_err}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 2'd0);

        // Reset mid-burst
        step(0, 1, 0, 0, 32'h700, 0, 0, 2'd2);
        step(0, 1, 0, 0, 32'h700, 0, 0, 2'd2);
        step(1, 1, 0, 0, 32'h704, 0, 0, 2'd2);
        check("plan_r_ren",  {31'd0, ramREN}, 32'd0);
        check("plan_r_err",  {31'd0, ram_err}, 32'd0);
        check("plan_r_wait", {31'd0, dwait}, 32'd1);
        step(0, 1, 0, 0, 32'h800, 0, 0, 2'd2);
        step(0, 1, 0, 0, 32'h800, 0, 0, 2'd2);
        step(0, 1, 0, 0, 32'h804, 0, 0, 2'd2);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 99);
            rs_r = (r < 60) ? 2'd2 : (r < 80) ? 2'd1 : (r < 93) ? 2'd0 : 2'd3;
            step($urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 65,
                 $urandom, $urandom, $urandom, rs_r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
